// File: rtl/line_scan_pkg.sv
// Shared constants and scan-state encoding for the terrain line reader.
package line_scan_pkg;

  localparam int LINE_W = 640;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

  // Terrain bit meaning
  localparam logic GROUND = 1'b1;
  localparam logic GAP    = 1'b0;

endpackage

// File: rtl/line_scan_fall_detect.sv
// Counts consecutive gap frames under the player and flags a fall once the run
// reaches FALL_FRAMES; fall_o pulses on that transition only.
module fall_detect
  import line_scan_pkg::*;
#(
  parameter int FALL_FRAMES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic frame_start_i,
  input  logic g_i,
  output logic fall_o,
  output logic fallen_o
);

  localparam logic [3:0] FF_MAX = 4'(FALL_FRAMES);

  logic [3:0] r_cnt;
  logic       r_fall;
  logic       r_fallen;
  logic       w_hit;

  // Only the step from FALL_FRAMES-1 into FALL_FRAMES fires; saturation holds off re-pulses.
  assign w_hit = frame_start_i && g_i && (r_cnt == FF_MAX - 4'd1);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_cnt    <= 4'd0;
      r_fall   <= 1'b0;
      r_fallen <= 1'b0;
    end else begin
      r_fall <= w_hit;
      if (w_hit) r_fallen <= 1'b1;
      if (frame_start_i) begin
        if (!g_i)                r_cnt <= 4'd0;
        else if (r_cnt < FF_MAX) r_cnt <= r_cnt + 4'd1;
      end
    end
  end

  assign fall_o   = r_fall;
  assign fallen_o = r_fallen;

endmodule

// File: rtl/line_scan.sv
// Snapshots the terrain line each frame and serialises it one pixel per accepted
// tick (leftmost column = shadow MSB); also feeds the player-column gap to fall_detect.
module line_scan
  import line_scan_pkg::*;
#(
  parameter int WIDTH       = LINE_W,
  parameter int PLAYER_X    = 100,
  parameter int FALL_FRAMES = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] line_i,
  input  logic             frame_start_i,
  input  logic             pix_en_i,
  input  logic             active_i,
  output logic             pix_o,
  output logic             pix_valid_o,
  output logic             gap_o,
  output logic             fall_o,
  output logic             fallen_o,
  output logic [1:0]       state_o
);

  localparam int              COL_W = $clog2(WIDTH);
  localparam logic [COL_W-1:0] LAST = COL_W'(WIDTH - 1);

  scan_state_e      r_state;
  scan_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_idx;
  logic             r_pix;
  logic             r_pix_valid;
  logic             r_gap;
  logic             w_accept;
  logic             w_g;

  // frame_start_i wins over a coincident tick, so no pixel leaves on a restart cycle.
  assign w_accept = (r_state == ST_SCAN) && pix_en_i && active_i && !frame_start_i;
  assign w_idx    = LAST - r_col;
  assign w_g      = (line_i[WIDTH-1-PLAYER_X] == GAP);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start_i)                   w_state_nxt = ST_SCAN;
    else if (w_accept && (r_col == LAST)) w_state_nxt = ST_DONE;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_shadow    <= '1;
      r_col       <= '0;
      r_pix       <= 1'b0;
      r_pix_valid <= 1'b0;
      r_gap       <= 1'b0;
    end else begin
      r_pix_valid <= w_accept;
      if (frame_start_i) begin
        r_shadow <= line_i;
        r_col    <= '0;
        r_gap    <= w_g;
      end else if (w_accept) begin
        r_pix <= r_shadow[w_idx];
        r_col <= (r_col == LAST) ? '0 : r_col + 1'b1;
      end
    end
  end

  fall_detect #(
    .FALL_FRAMES(FALL_FRAMES)
  ) u_fall_detect (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .frame_start_i (frame_start_i),
    .g_i           (w_g),
    .fall_o        (fall_o),
    .fallen_o      (fallen_o)
  );

  assign pix_o       = r_pix;
  assign pix_valid_o = r_pix_valid;
  assign gap_o       = r_gap;
  assign state_o     = r_state;

endmodule

// File: tb/tb_line_scan.sv
// Directed bench for line_scan: serialisation order, pause/restart, fall detection, async reset.
module tb_line_scan;

  localparam int W = 640;

  logic         clk = 1'b0;
  logic         reset_i;
  logic [W-1:0] line_i;
  logic         frame_start_i;
  logic         pix_en_i;
  logic         active_i;
  logic         pix_o;
  logic         pix_valid_o;
  logic         gap_o;
  logic         fall_o;
  logic         fallen_o;
  logic [1:0]   state_o;

  int checks     = 0;
  int errors     = 0;
  int fall_seen  = 0;
  int valid_seen = 0;
  int sb_mis     = 0;
  logic [0:0] exp_q[$];

  logic [W-1:0] pat;
  logic [W-1:0] gline;

  line_scan dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .line_i        (line_i),
    .frame_start_i (frame_start_i),
    .pix_en_i      (pix_en_i),
    .active_i      (active_i),
    .pix_o         (pix_o),
    .pix_valid_o   (pix_valid_o),
    .gap_o         (gap_o),
    .fall_o        (fall_o),
    .fallen_o      (fallen_o),
    .state_o       (state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver: hold inputs for one clock, then observe 1 ns after the edge
  task automatic cyc(input logic fs, input logic pe, input logic act);
    frame_start_i = fs;
    pix_en_i      = pe;
    active_i      = act;
    @(posedge clk);
    #1;
    if (fall_o) fall_seen++;
    if (pix_valid_o) valid_seen++;
  endtask

  task automatic sb_step();
    logic [0:0] e;
    if (pix_valid_o) begin
      if (exp_q.size() == 0) sb_mis++;
      else begin
        e = exp_q.pop_front();
        if (pix_o !== e[0]) sb_mis++;
      end
    end
  endtask

  task automatic do_reset();
    reset_i       = 1'b0;
    frame_start_i = 1'b0;
    pix_en_i      = 1'b0;
    active_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_i    = 1'b1;
    fall_seen  = 0;
    valid_seen = 0;
  endtask

  initial begin
    int mis;
    line_i = '0;
    pat    = {20{32'hA5C3_0F96}};
    gline  = '1;
    gline[W-1-100] = 1'b0;

    // T1: reset state, ticks without a frame start do nothing
    do_reset();
    check("rst_pix", 32'(pix_o), 0);
    check("rst_valid", 32'(pix_valid_o), 0);
    check("rst_gap", 32'(gap_o), 0);
    check("rst_fall", 32'(fall_o), 0);
    check("rst_fallen", 32'(fallen_o), 0);
    check("rst_state", 32'(state_o), 0);
    repeat (700) cyc(1'b0, 1'b1, 1'b1);
    check("t1_no_valid", 32'(valid_seen), 0);
    check("t1_pix", 32'(pix_o), 0);
    check("t1_fallen", 32'(fallen_o), 0);
    check("t1_state", 32'(state_o), 0);

    // T2: single set bit at LSB appears only at x = 639
    do_reset();
    line_i = '0;
    line_i[0] = 1'b1;
    cyc(1'b1, 1'b0, 1'b1);
    check("t2_state_scan", 32'(state_o), 1);
    check("t2_gap", 32'(gap_o), 1);
    mis = 0;
    for (int x = 0; x < W; x++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (pix_valid_o !== 1'b1 || pix_o !== (x == W - 1)) mis++;
    end
    check("t2_pix_seq", 32'(mis), 0);
    check("t2_state_done", 32'(state_o), 2);
    cyc(1'b0, 1'b1, 1'b1);
    check("t2_tick641_valid", 32'(pix_valid_o), 0);
    check("t2_tick641_pix_hold", 32'(pix_o), 1);

    // T3: pause active at x = 300 for 20 ticks, sequence must resume seamlessly
    line_i = pat;
    exp_q.delete();
    for (int x = 0; x < W; x++) exp_q.push_back(pat[W-1-x]);
    sb_mis = 0;
    cyc(1'b1, 1'b0, 1'b1);
    valid_seen = 0;
    for (int x = 0; x < 300; x++) begin cyc(1'b0, 1'b1, 1'b1); sb_step(); end
    for (int x = 0; x < 20; x++)  begin cyc(1'b0, 1'b1, 1'b0); sb_step(); end
    check("t3_valid_pause", 32'(valid_seen), 300);
    for (int x = 0; x < 340; x++) begin cyc(1'b0, 1'b1, 1'b1); sb_step(); end
    check("t3_valid_total", 32'(valid_seen), 640);
    check("t3_sb_mismatch", 32'(sb_mis), 0);
    check("t3_sb_left", 32'(exp_q.size()), 0);
    check("t3_state_done", 32'(state_o), 2);

    // T6: restart at x = 200 coinciding with a tick
    line_i = pat;
    cyc(1'b1, 1'b0, 1'b1);
    repeat (200) cyc(1'b0, 1'b1, 1'b1);
    line_i = '1;
    cyc(1'b1, 1'b1, 1'b1);
    check("t6_restart_valid", 32'(pix_valid_o), 0);
    check("t6_restart_state", 32'(state_o), 1);
    line_i = pat;
    cyc(1'b0, 1'b1, 1'b1);
    check("t6_x0_valid", 32'(pix_valid_o), 1);
    check("t6_x0_pix", 32'(pix_o), 1);

    // T4: gap under player for 3 frames, then a fresh run re-pulses
    do_reset();
    line_i = gline;
    cyc(1'b1, 1'b0, 1'b0);
    check("t4_f1_gap", 32'(gap_o), 1);
    check("t4_f1_fall", 32'(fall_o), 0);
    check("t4_f1_fallen", 32'(fallen_o), 0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t4_f2_fall", 32'(fall_o), 1);
    check("t4_f2_fallen", 32'(fallen_o), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t4_f2_pulse_end", 32'(fall_o), 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t4_f3_fall", 32'(fall_o), 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    check("t4_one_pulse", 32'(fall_seen), 1);
    line_i = '1;
    cyc(1'b1, 1'b0, 1'b0);
    check("t4_clear_gap", 32'(gap_o), 0);
    line_i = gline;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("t4_repulse", 32'(fall_o), 1);
    cyc(1'b0, 1'b0, 1'b0);
    check("t4_two_pulses", 32'(fall_seen), 2);
    check("t4_fallen_sticky", 32'(fallen_o), 1);

    // T5: alternating gap/ground never reaches the threshold
    do_reset();
    for (int f = 0; f < 4; f++) begin
      line_i = (f % 2 == 0) ? gline : {W{1'b1}};
      cyc(1'b1, 1'b0, 1'b0);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
    end
    check("t5_no_fall", 32'(fall_seen), 0);
    check("t5_fallen", 32'(fallen_o), 0);
    check("t5_gap", 32'(gap_o), 0);
    line_i = gline;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("t5_late_fall", 32'(fall_seen), 1);

    // T7: asynchronous reset mid-scan at x = 400
    line_i = gline;
    cyc(1'b1, 1'b0, 1'b1);
    repeat (400) cyc(1'b0, 1'b1, 1'b1);
    check("t7_pre_pix", 32'(pix_o), 1);
    check("t7_pre_valid", 32'(pix_valid_o), 1);
    check("t7_pre_fallen", 32'(fallen_o), 1);
    reset_i = 1'b0;
    #1;
    check("t7_async_pix", 32'(pix_o), 0);
    check("t7_async_valid", 32'(pix_valid_o), 0);
    check("t7_async_gap", 32'(gap_o), 0);
    check("t7_async_fallen", 32'(fallen_o), 0);
    check("t7_async_state", 32'(state_o), 0);
    @(posedge clk);
    #1;
    reset_i    = 1'b1;
    valid_seen = 0;
    repeat (50) cyc(1'b0, 1'b1, 1'b1);
    check("t7_post_no_valid", 32'(valid_seen), 0);
    check("t7_post_idle", 32'(state_o), 0);
    cyc(1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    check("t7_post_first_valid", 32'(pix_valid_o), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/line_scan.md
Name: line_scan

Overview:
- Reader for the 640-bit scrolling terrain line: snapshots the line once per video frame and serialises it one pixel per pixel tick for the VGA renderer.
- Also checks the terrain column under the player and raises a fall event after a gap persists for a set number of frames.
- Sits between the terrain line generator and the VGA pixel mux and game-control FSM.

Parameters:
- WIDTH, 640, line length in bits, equal to the visible pixels per row
- PLAYER_X, 100, screen column of the player (0..WIDTH-1)
- FALL_FRAMES, 2, consecutive gap frames that trigger a fall (1..15)

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous active-low reset
- line_i  input  WIDTH  terrain line (1 = solid ground, 0 = gap); bit 0 = newest bit
- frame_start_i  input  1  one-cycle pulse at the start of each frame (vsync edge)
- pix_en_i  input  1  pixel tick
- active_i  input  1  high in the visible horizontal region
- pix_o  output  1  terrain pixel for the current column
- pix_valid_o  output  1  pix_o holds a new pixel this cycle
- gap_o  output  1  latched: the player column was a gap at the last snapshot
- fall_o  output  1  one-cycle fall pulse
- fallen_o  output  1  sticky fall flag, cleared only by reset

Behaviour:
- Clock and reset: single clock clk_i; reset_i is asynchronous, active-low.
- Reset values:
  - shadow register all ones; col = 0; state IDLE
  - pix_o = 0, pix_valid_o = 0, gap_o = 0, fall_o = 0, fallen_o = 0
  - gap counter = 0
- Mapping: screen column x displays shadow[WIDTH-1-x]. New bits enter at the right edge and scroll left.
- FSM states: IDLE, SCAN, DONE.
  - IDLE/DONE -> SCAN on frame_start_i. The snapshot is taken that cycle: shadow <= line_i, col <= 0.
  - SCAN: on each cycle with pix_en_i && active_i, pix_o <= shadow[WIDTH-1-col] and pix_valid_o <= 1. col increments.
  - Latency is one clock from the accepted tick to pix_o.
  - When col == WIDTH-1 is emitted, go to DONE and reset col to 0.
  - frame_start_i while in SCAN restarts the scan: re-snapshot, col = 0.
- pix_valid_o is 0 on every cycle without an accepted tick. pix_o holds its last value.
- Ticks with active_i = 0, or in IDLE/DONE, are ignored and do not advance col.
- frame_start_i has priority when it coincides with pix_en_i: no pixel is emitted that cycle.
- Gap check, done on each frame_start_i:
  - g = ~line_i[WIDTH-1-PLAYER_X], evaluated on the incoming value, not the old shadow.
  - gap_o <= g.
  - If g, the counter increments, saturating at FALL_FRAMES. Otherwise the counter clears.
  - When the counter transitions to FALL_FRAMES, fall_o pulses for exactly one cycle and fallen_o sets.
  - fall_o does not re-pulse while the gap persists. A counter clear followed by a new gap run pulses again; fallen_o stays 1.
- Reset asserted mid-scan returns all state to reset values immediately. The first snapshot happens at the next frame_start_i after release.
- Width rules:
  - col is clog2(WIDTH) bits and never exceeds WIDTH-1.
  - The gap counter is 4 bits.

Decomposition:
- Shared package holds:
  - LINE_W = 640
  - the scan state encoding (IDLE=0, SCAN=1, DONE=2)
  - bit semantics constants GROUND = 1, GAP = 0
- One natural sub-module: fall_detect. It contains the gap counter, fall pulse and sticky flag. Its inputs are frame_start_i and g.
- The serialiser FSM stays in line_scan.

Test Plan:
- Reset then release with no frame_start_i, apply 700 ticks with active_i = 1 -> pix_valid_o never asserts; pix_o = 0; fallen_o = 0.
- Set line_i = 640'h1 (only bit 0 set), pulse frame_start_i, then 640 ticks -> pix_o = 0 for x = 0..638 and pix_o = 1 at x = 639. The FSM ends in DONE, and a 641st tick gives no valid.
- Start a scan, toggle active_i low for 20 ticks at x = 300, then high -> the x sequence resumes at 300 with no skipped or duplicated pixels.
- With FALL_FRAMES = 2 and line_i bit 539 (PLAYER_X = 100) = 0 for 3 frames -> gap_o = 1 after frame 1. fall_o pulses once at the frame-2 snapshot and fallen_o = 1; no pulse at frame 3.
- Gap pattern over frames 0,1,0,0 -> no fall_o pulse; the counter clears after frame 1.
- Pulse frame_start_i at x = 200 together with pix_en_i, with new line_i = all ones -> no valid that cycle; the next tick gives x = 0 with pix_o = 1.
- Assert reset_i low at x = 400 mid-scan -> all outputs are 0 within the same cycle (asynchronous); after release, state is IDLE until frame_start_i.
